// File: rtl/regdump_pkg.sv
// regdump_pkg: shared state encoding and default widths for the register dump reader.
package regdump_pkg;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int DEF_DATA_W   = 32;
   typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
endpackage

// File: rtl/regdump_csum.sv
// regdump_csum: XOR accumulator over dumped words, cleared on an accepted start.
module regdump_csum #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_acc
);
   logic [DATA_W-1:0] r_acc;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_en) r_acc <= r_acc ^ i_data;
   end
   assign o_acc = r_acc;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through the regfile read port and streams words out.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              Abort,
   input  logic [ADDR_W-1:0] FirstReg,
   input  logic [ADDR_W-1:0] LastReg,
   output logic [ADDR_W-1:0] ReadRegister,
   input  logic [DATA_W-1:0] ReadData,
   output logic              DumpValid,
   input  logic              DumpReady,
   output logic [DATA_W-1:0] DumpData,
   output logic [ADDR_W-1:0] DumpAddr,
   output logic              DumpLast,
   output logic              Busy,
   output logic              Done
);
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_idx, r_last, r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_start, w_hs, w_at_last;
   assign w_start   = r_state == IDLE && Start && !Abort;
   assign w_hs      = r_state == SEND && DumpReady && !Abort;
   assign w_at_last = r_idx == r_last;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (Start) w_next = FirstReg <= LastReg ? FETCH : DONE;
         FETCH: w_next = SEND;
`ifdef REGDUMP_CHECKSUM_EN
         SEND:  if (DumpReady) w_next = w_at_last ? CSUM : FETCH;
         CSUM:  if (DumpReady) w_next = DONE;
`else
         SEND:  if (DumpReady) w_next = w_at_last ? DONE : FETCH;
`endif
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (Abort) w_next = IDLE;
   end
   // idx stops at LastReg so a range ending at the top register never wraps
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_last  <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_idx  <= FirstReg;
            r_last <= LastReg;
         end
         if (r_state == FETCH && !Abort) begin
            r_data <= ReadData;
            r_addr <= r_idx;
         end
         if (w_hs && !w_at_last) r_idx <= r_idx + 1'b1;
      end
   end
   assign ReadRegister = r_idx;
   assign Busy         = r_state != IDLE;
   assign Done         = r_state == DONE;
`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] w_csum;
   regdump_csum #(.DATA_W(DATA_W)) u_csum (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .i_clr   (w_start),
      .i_en    (w_hs),
      .i_data  (r_data),
      .o_acc   (w_csum)
   );
   assign DumpValid = r_state == SEND || r_state == CSUM;
   assign DumpData  = r_state == CSUM ? w_csum : r_data;
   assign DumpAddr  = r_state == CSUM ? '0 : r_addr;
   assign DumpLast  = r_state == CSUM;
`else
   assign DumpValid = r_state == SEND;
   assign DumpData  = r_data;
   assign DumpAddr  = r_addr;
   assign DumpLast  = DumpValid && r_addr == r_last;
`endif
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed bench for regfile_dump_reader with a behavioural regfile.
module tb_regfile_dump_reader;
   logic        Clk = 0, Reset_n = 0, Start = 0, Abort = 0, DumpReady = 0;
   logic [4:0]  FirstReg = 0, LastReg = 0, ReadRegister, DumpAddr;
   logic [31:0] ReadData, DumpData;
   logic        DumpValid, DumpLast, Busy, Done;
   logic [31:0] regs [32];
   int          n_pass = 0, n_tot = 0, n_fail = 0;
`ifdef REGDUMP_CHECKSUM_EN
   localparam logic LAST_ON_WORD = 1'b0;
`else
   localparam logic LAST_ON_WORD = 1'b1;
`endif

   always #5 Clk = ~Clk;
   assign ReadData = regs[ReadRegister];

   regfile_dump_reader dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .FirstReg(FirstReg), .LastReg(LastReg), .ReadRegister(ReadRegister),
      .ReadData(ReadData), .DumpValid(DumpValid), .DumpReady(DumpReady),
      .DumpData(DumpData), .DumpAddr(DumpAddr), .DumpLast(DumpLast),
      .Busy(Busy), .Done(Done)
   );

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!DumpValid && n < 8) begin
         tick;
         n++;
      end
      chk(tag, {31'd0, DumpValid}, 32'd1);
   endtask

   task automatic dump(input int f, input int l, input int stall, input int abort_at);
      logic [31:0] acc = '0;
      FirstReg  = 5'(f);
      LastReg   = 5'(l);
      Start     = 1;
      DumpReady = stall == 0;
      tick;
      Start = 0;
      chk("fetch_valid", {31'd0, DumpValid}, 32'd0);
      chk("fetch_busy", {31'd0, Busy}, 32'd1);
      for (int a = f; a <= l; a++) begin
         wait_valid("valid");
         if (a == abort_at) begin
            Abort = 1;
            chk("abort_addr", {27'd0, DumpAddr}, a);
            tick;
            Abort = 0;
            chk("abort_valid", {31'd0, DumpValid}, 32'd0);
            chk("abort_busy", {31'd0, Busy}, 32'd0);
            chk("abort_done", {31'd0, Done}, 32'd0);
            chk("abort_idx", {27'd0, ReadRegister}, a);
            return;
         end
         for (int k = 0; k < stall; k++) begin
            Start    = k == 0;
            FirstReg = 5'd0;
            LastReg  = 5'd31;
            chk("stall_valid", {31'd0, DumpValid}, 32'd1);
            chk("stall_data", DumpData, regs[a]);
            chk("stall_addr", {27'd0, DumpAddr}, a);
            chk("stall_rdreg", {27'd0, ReadRegister}, a);
            tick;
         end
         Start     = 0;
         DumpReady = 1;
         chk("data", DumpData, regs[a]);
         chk("addr", {27'd0, DumpAddr}, a);
         chk("last", {31'd0, DumpLast}, {31'd0, LAST_ON_WORD && a == l});
         acc ^= regs[a];
         tick;
         DumpReady = stall == 0;
      end
`ifdef REGDUMP_CHECKSUM_EN
      DumpReady = 1;
      wait_valid("csum_valid");
      chk("csum_data", DumpData, acc);
      chk("csum_addr", {27'd0, DumpAddr}, 32'd0);
      chk("csum_last", {31'd0, DumpLast}, 32'd1);
      tick;
`endif
      chk("done_pulse", {31'd0, Done}, 32'd1);
      chk("done_valid", {31'd0, DumpValid}, 32'd0);
      tick;
      chk("done_clear", {31'd0, Done}, 32'd0);
      chk("idle_busy", {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 * i + 32'h0000_5A00 + i;
      regs[0]  = 32'hDEAD_0000;
      regs[1]  = 32'h1111_1111;
      regs[2]  = 32'h2222_2222;
      regs[3]  = 32'h3333_3333;
      regs[31] = 32'hABCD_EFFF;
      repeat (2) tick;
      chk("rst_valid", {31'd0, DumpValid}, 32'd0);
      chk("rst_data", DumpData, 32'd0);
      chk("rst_addr", {27'd0, DumpAddr}, 32'd0);
      chk("rst_last", {31'd0, DumpLast}, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_rdreg", {27'd0, ReadRegister}, 32'd0);
      Reset_n = 1;
      tick;
      Abort = 1;
      tick;
      Abort = 0;
      chk("idle_abort_busy", {31'd0, Busy}, 32'd0);
      Start = 1; Abort = 1; FirstReg = 5'd1; LastReg = 5'd3;
      tick;
      Start = 0; Abort = 0;
      chk("start_abort_busy", {31'd0, Busy}, 32'd0);
      chk("start_abort_valid", {31'd0, DumpValid}, 32'd0);
      dump(1, 3, 0, -1);
      dump(1, 3, 5, -1);
      dump(31, 31, 0, -1);
      chk("no_wrap_idx", {27'd0, ReadRegister}, 32'd31);
      FirstReg = 5'd5; LastReg = 5'd2; Start = 1;
      tick;
      Start = 0;
      chk("empty_done", {31'd0, Done}, 32'd1);
      chk("empty_valid", {31'd0, DumpValid}, 32'd0);
      tick;
      chk("empty_done_clear", {31'd0, Done}, 32'd0);
      chk("empty_busy", {31'd0, Busy}, 32'd0);
      chk("empty_valid2", {31'd0, DumpValid}, 32'd0);
      dump(0, 31, 0, 7);
      tick;
      chk("abort_no_late_done", {31'd0, Done}, 32'd0);
      dump(0, 31, 0, -1);
      chk("pre_reset_data", DumpData, regs[31]);
      FirstReg = 5'd1; LastReg = 5'd3; Start = 1; DumpReady = 1;
      tick;
      Start = 0;
      chk("mid_fetch_busy", {31'd0, Busy}, 32'd1);
      #2 Reset_n = 0;
      #1;
      chk("async_valid", {31'd0, DumpValid}, 32'd0);
      chk("async_data", DumpData, 32'd0);
      chk("async_addr", {27'd0, DumpAddr}, 32'd0);
      chk("async_last", {31'd0, DumpLast}, 32'd0);
      chk("async_busy", {31'd0, Busy}, 32'd0);
      chk("async_rdreg", {27'd0, ReadRegister}, 32'd0);
      tick;
      Reset_n = 1;
      dump(2, 3, 0, -1);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
